// File: rtl/pe_sequencer.sv
// Pass sequencer for one processing element: it pushes a config word, then the filter beats,
// then runs the ifmap, ipsum and opsum streams side by side until each has reached its beat count.
module pe_sequencer #(
    parameter int DATA_SIZE  = 8,
    parameter int FILTER_NUM = 4,
    parameter int CFG_BITS   = 44,
    parameter int CNT_BIT    = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [CFG_BITS-1:0]               cfg_word,
    input  logic [CNT_BIT-1:0]                filter_cnt,
    input  logic [CNT_BIT-1:0]                ifmap_cnt,
    input  logic [CNT_BIT-1:0]                ipsum_cnt,
    input  logic [CNT_BIT-1:0]                opsum_cnt,
    input  logic [FILTER_NUM*DATA_SIZE:0]     src_filter,
    output logic                              src_filter_ready,
    input  logic [DATA_SIZE:0]                src_ifmap,
    output logic                              src_ifmap_ready,
    input  logic [DATA_SIZE:0]                src_ipsum,
    output logic                              src_ipsum_ready,
    output logic [CFG_BITS:0]                 pe_config,
    output logic                              pe_enable,
    output logic [FILTER_NUM*DATA_SIZE:0]     pe_filter,
    input  logic                              pe_filter_ready,
    output logic [DATA_SIZE:0]                pe_ifmap,
    input  logic                              pe_ifmap_ready,
    output logic [DATA_SIZE:0]                pe_ipsum,
    input  logic                              pe_ipsum_ready,
    input  logic [DATA_SIZE:0]                pe_opsum,
    output logic                              pe_opsum_ready,
    output logic [DATA_SIZE:0]                dst_opsum,
    input  logic                              dst_opsum_ready,
    output logic                              busy,
    output logic                              done
);

    localparam int FW = FILTER_NUM * DATA_SIZE;
    localparam logic [CNT_BIT-1:0] CNT_ONE = CNT_BIT'(1);

    typedef enum logic [2:0] {IDLE, CONFIG, FILTER, COMPUTE, DONE} state_t;

    state_t               state_q, state_d;
    logic [CFG_BITS-1:0]  cfg_q, cfg_d;
    logic [CNT_BIT-1:0]   filter_tgt_q, filter_tgt_d, ifmap_tgt_q, ifmap_tgt_d;
    logic [CNT_BIT-1:0]   ipsum_tgt_q, ipsum_tgt_d, opsum_tgt_q, opsum_tgt_d;
    logic [CNT_BIT-1:0]   filter_beats_q, filter_beats_d, ifmap_beats_q, ifmap_beats_d;
    logic [CNT_BIT-1:0]   ipsum_beats_q, ipsum_beats_d, opsum_beats_q, opsum_beats_d;

    logic open_filter, open_ifmap, open_ipsum, open_opsum;
    logic xfer_filter, xfer_ifmap, xfer_ipsum, xfer_opsum;

    // A stream is open only in its phase and only until its beat target is reached.
    assign open_filter = (state_q == FILTER)  && (filter_beats_q != filter_tgt_q);
    assign open_ifmap  = (state_q == COMPUTE) && (ifmap_beats_q  != ifmap_tgt_q);
    assign open_ipsum  = (state_q == COMPUTE) && (ipsum_beats_q  != ipsum_tgt_q);
    assign open_opsum  = (state_q == COMPUTE) && (opsum_beats_q  != opsum_tgt_q);

    assign xfer_filter = open_filter && src_filter[FW]       && pe_filter_ready;
    assign xfer_ifmap  = open_ifmap  && src_ifmap[DATA_SIZE] && pe_ifmap_ready;
    assign xfer_ipsum  = open_ipsum  && src_ipsum[DATA_SIZE] && pe_ipsum_ready;
    assign xfer_opsum  = open_opsum  && pe_opsum[DATA_SIZE]  && dst_opsum_ready;

    assign pe_filter        = {src_filter[FW] && open_filter, src_filter[FW-1:0]};
    assign src_filter_ready = pe_filter_ready && open_filter;
    assign pe_ifmap         = {src_ifmap[DATA_SIZE] && open_ifmap, src_ifmap[DATA_SIZE-1:0]};
    assign src_ifmap_ready  = pe_ifmap_ready && open_ifmap;
    assign pe_ipsum         = {src_ipsum[DATA_SIZE] && open_ipsum, src_ipsum[DATA_SIZE-1:0]};
    assign src_ipsum_ready  = pe_ipsum_ready && open_ipsum;
    assign dst_opsum        = {pe_opsum[DATA_SIZE] && open_opsum, pe_opsum[DATA_SIZE-1:0]};
    assign pe_opsum_ready   = dst_opsum_ready && open_opsum;

    assign pe_config = {state_q == CONFIG, cfg_q};
    assign pe_enable = (state_q == CONFIG) || (state_q == FILTER) || (state_q == COMPUTE);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);

    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d        = state_q;
        cfg_d          = cfg_q;
        filter_tgt_d   = filter_tgt_q;
        ifmap_tgt_d    = ifmap_tgt_q;
        ipsum_tgt_d    = ipsum_tgt_q;
        opsum_tgt_d    = opsum_tgt_q;
        filter_beats_d = xfer_filter ? filter_beats_q + CNT_ONE : filter_beats_q;
        ifmap_beats_d  = xfer_ifmap  ? ifmap_beats_q  + CNT_ONE : ifmap_beats_q;
        ipsum_beats_d  = xfer_ipsum  ? ipsum_beats_q  + CNT_ONE : ipsum_beats_q;
        opsum_beats_d  = xfer_opsum  ? opsum_beats_q  + CNT_ONE : opsum_beats_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    cfg_d          = cfg_word;
                    filter_tgt_d   = filter_cnt;
                    ifmap_tgt_d    = ifmap_cnt;
                    ipsum_tgt_d    = ipsum_cnt;
                    opsum_tgt_d    = opsum_cnt;
                    filter_beats_d = '0;
                    ifmap_beats_d  = '0;
                    ipsum_beats_d  = '0;
                    opsum_beats_d  = '0;
                    state_d        = CONFIG;
                end
            end
            CONFIG:  state_d = (filter_tgt_q != '0) ? FILTER : COMPUTE;
            // Comparing the next-cycle count folds in a beat landing this cycle.
            FILTER: begin
                if (filter_beats_d == filter_tgt_q) state_d = COMPUTE;
            end
            COMPUTE: begin
                if ((ifmap_beats_d == ifmap_tgt_q) && (ipsum_beats_d == ipsum_tgt_q) &&
                    (opsum_beats_d == opsum_tgt_q)) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            cfg_q          <= '0;
            filter_tgt_q   <= '0;
            ifmap_tgt_q    <= '0;
            ipsum_tgt_q    <= '0;
            opsum_tgt_q    <= '0;
            filter_beats_q <= '0;
            ifmap_beats_q  <= '0;
            ipsum_beats_q  <= '0;
            opsum_beats_q  <= '0;
        end else begin
            state_q        <= state_d;
            cfg_q          <= cfg_d;
            filter_tgt_q   <= filter_tgt_d;
            ifmap_tgt_q    <= ifmap_tgt_d;
            ipsum_tgt_q    <= ipsum_tgt_d;
            opsum_tgt_q    <= opsum_tgt_d;
            filter_beats_q <= filter_beats_d;
            ifmap_beats_q  <= ifmap_beats_d;
            ipsum_beats_q  <= ipsum_beats_d;
            opsum_beats_q  <= opsum_beats_d;
        end
    end

endmodule

// File: tb/tb_pe_sequencer.sv
// Directed bench for pe_sequencer: a linear series of passes, each output checked against
// values worked out by hand from the cycle-by-cycle behaviour of the sequencer.
module tb_pe_sequencer;

    localparam int DS  = 8;
    localparam int FN  = 4;
    localparam int CFB = 44;
    localparam int CB  = 16;
    localparam int FW  = FN * DS;

    logic              clk, rst, start;
    logic [CFB-1:0]    cfg_word;
    logic [CB-1:0]     filter_cnt, ifmap_cnt, ipsum_cnt, opsum_cnt;
    logic [FW:0]       src_filter, pe_filter;
    logic [DS:0]       src_ifmap, src_ipsum, pe_ifmap, pe_ipsum, pe_opsum, dst_opsum;
    logic              src_filter_ready, src_ifmap_ready, src_ipsum_ready;
    logic [CFB:0]      pe_config;
    logic              pe_enable, pe_filter_ready, pe_ifmap_ready, pe_ipsum_ready;
    logic              pe_opsum_ready, dst_opsum_ready, busy, done;

    int pass_cnt = 0;
    int total_cnt = 0;

    pe_sequencer #(.DATA_SIZE(DS), .FILTER_NUM(FN), .CFG_BITS(CFB), .CNT_BIT(CB)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_word(cfg_word),
        .filter_cnt(filter_cnt), .ifmap_cnt(ifmap_cnt), .ipsum_cnt(ipsum_cnt), .opsum_cnt(opsum_cnt),
        .src_filter(src_filter), .src_filter_ready(src_filter_ready),
        .src_ifmap(src_ifmap), .src_ifmap_ready(src_ifmap_ready),
        .src_ipsum(src_ipsum), .src_ipsum_ready(src_ipsum_ready),
        .pe_config(pe_config), .pe_enable(pe_enable),
        .pe_filter(pe_filter), .pe_filter_ready(pe_filter_ready),
        .pe_ifmap(pe_ifmap), .pe_ifmap_ready(pe_ifmap_ready),
        .pe_ipsum(pe_ipsum), .pe_ipsum_ready(pe_ipsum_ready),
        .pe_opsum(pe_opsum), .pe_opsum_ready(pe_opsum_ready),
        .dst_opsum(dst_opsum), .dst_opsum_ready(dst_opsum_ready),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic status(input string tag, input logic b, input logic d, input logic en,
                          input logic set);
        check({tag, ".busy"}, 64'(busy), 64'(b));
        check({tag, ".done"}, 64'(done), 64'(d));
        check({tag, ".pe_enable"}, 64'(pe_enable), 64'(en));
        check({tag, ".set_info"}, 64'(pe_config[CFB]), 64'(set));
    endtask

    initial begin
        logic [CFB-1:0] cfg_a, cfg_b;
        cfg_a = 44'hABCDEF01234;
        cfg_b = 44'h13579BDF024;

        rst = 1'b1; start = 1'b0; cfg_word = cfg_a;
        filter_cnt = '0; ifmap_cnt = '0; ipsum_cnt = '0; opsum_cnt = '0;
        src_filter = '0; src_ifmap = '0; src_ipsum = '0; pe_opsum = '0;
        pe_filter_ready = 1'b1; pe_ifmap_ready = 1'b1; pe_ipsum_ready = 1'b1;
        dst_opsum_ready = 1'b1;
        tick(); tick(); #1;
        status("reset", 0, 0, 0, 0);
        check("reset.pe_config", 64'(pe_config), 64'(0));
        check("reset.src_filter_ready", 64'(src_filter_ready), 64'(0));
        check("reset.pe_opsum_ready", 64'(pe_opsum_ready), 64'(0));

        // All counts zero: start, CONFIG, COMPUTE, DONE.
        rst = 1'b0; start = 1'b1;
        tick(); start = 1'b0;
        src_ifmap = {1'b1, 8'h3C}; #1;
        status("zero.config", 1, 0, 1, 1);
        check("zero.cfg_payload", 64'(pe_config), 64'({1'b1, cfg_a}));
        tick(); #1;
        status("zero.compute", 1, 0, 1, 0);
        check("zero.ifmap_en", 64'(pe_ifmap[DS]), 64'(0));
        check("zero.ifmap_ready", 64'(src_ifmap_ready), 64'(0));
        tick(); #1;
        status("zero.done", 1, 1, 0, 0);
        tick(); #1;
        status("zero.idle", 0, 0, 0, 0);
        src_ifmap = '0;

        // Filter pass of 3 beats with sink ready 1,0,1,1; start pulsed in FILTER and in DONE.
        filter_cnt = 16'd3; start = 1'b1;
        tick(); start = 1'b0;
        tick();
        src_filter = {1'b1, 32'hA1B2C3D4}; pe_filter_ready = 1'b1; #1;
        status("filt.f1", 1, 0, 1, 0);
        check("filt.f1.pe_filter", 64'(pe_filter), 64'({1'b1, 32'hA1B2C3D4}));
        check("filt.f1.ready", 64'(src_filter_ready), 64'(1));
        tick();
        src_filter = {1'b1, 32'h0F1E2D3C}; pe_filter_ready = 1'b0; start = 1'b1; #1;
        check("filt.f2.pe_filter", 64'(pe_filter), 64'({1'b1, 32'h0F1E2D3C}));
        check("filt.f2.ready", 64'(src_filter_ready), 64'(0));
        tick(); start = 1'b0;
        pe_filter_ready = 1'b1; #1;
        status("filt.f3", 1, 0, 1, 0);
        check("filt.f3.pe_filter", 64'(pe_filter), 64'({1'b1, 32'h0F1E2D3C}));
        check("filt.f3.ready", 64'(src_filter_ready), 64'(1));
        tick();
        src_filter = {1'b1, 32'h99887766}; #1;
        check("filt.f4.pe_filter", 64'(pe_filter), 64'({1'b1, 32'h99887766}));
        check("filt.f4.ready", 64'(src_filter_ready), 64'(1));
        tick();
        src_filter = {1'b1, 32'h55555555}; #1;
        status("filt.compute", 1, 0, 1, 0);
        check("filt.extra.ready", 64'(src_filter_ready), 64'(0));
        check("filt.extra.en", 64'(pe_filter[FW]), 64'(0));
        tick(); start = 1'b1; #1;
        status("filt.done", 1, 1, 0, 0);
        tick(); start = 1'b0; #1;
        status("filt.start_in_done", 0, 0, 0, 0);
        tick(); #1;
        status("filt.still_idle", 0, 0, 0, 0);
        src_filter = '0;

        // Compute pass: ifmap 4, ipsum 2, opsum 2 with the opsum sink stalled 5 cycles.
        filter_cnt = '0; ifmap_cnt = 16'd4; ipsum_cnt = 16'd2; opsum_cnt = 16'd2;
        start = 1'b1;
        tick(); start = 1'b0; #1;
        status("comp.config", 1, 0, 1, 1);
        tick();
        src_ifmap = {1'b1, 8'h11}; src_ipsum = {1'b1, 8'h22}; pe_opsum = {1'b1, 8'h5A};
        dst_opsum_ready = 1'b0; #1;
        status("comp.c1", 1, 0, 1, 0);
        check("comp.c1.ifmap", 64'(pe_ifmap), 64'({1'b1, 8'h11}));
        check("comp.c1.ipsum", 64'(pe_ipsum), 64'({1'b1, 8'h22}));
        check("comp.c1.dst_valid", 64'(dst_opsum), 64'({1'b1, 8'h5A}));
        check("comp.c1.opsum_ready", 64'(pe_opsum_ready), 64'(0));
        tick(); tick(); #1;
        check("comp.c3.ipsum_en", 64'(pe_ipsum[DS]), 64'(0));
        check("comp.c3.ipsum_ready", 64'(src_ipsum_ready), 64'(0));
        check("comp.c3.ifmap_ready", 64'(src_ifmap_ready), 64'(1));
        tick(); tick(); #1;
        status("comp.c5", 1, 0, 1, 0);
        check("comp.c5.ifmap_en", 64'(pe_ifmap[DS]), 64'(0));
        check("comp.c5.ifmap_ready", 64'(src_ifmap_ready), 64'(0));
        tick();
        dst_opsum_ready = 1'b1; #1;
        check("comp.c6.opsum_ready", 64'(pe_opsum_ready), 64'(1));
        tick(); #1;
        status("comp.c7", 1, 0, 1, 0);
        check("comp.c7.opsum_ready", 64'(pe_opsum_ready), 64'(1));
        tick(); #1;
        status("comp.done", 1, 1, 0, 0);
        check("comp.done.dst_valid", 64'(dst_opsum[DS]), 64'(0));
        check("comp.done.opsum_ready", 64'(pe_opsum_ready), 64'(0));
        tick(); #1;
        status("comp.idle", 0, 0, 0, 0);

        // Abort mid-COMPUTE after one of four ifmap beats, then replay.
        ifmap_cnt = 16'd4; ipsum_cnt = '0; opsum_cnt = '0; start = 1'b1;
        src_ipsum = '0; pe_opsum = '0;
        tick(); start = 1'b0;
        tick(); #1;
        check("abort.c1.ifmap_ready", 64'(src_ifmap_ready), 64'(1));
        tick();
        rst = 1'b1; start = 1'b1; #1;
        status("abort.c2", 1, 0, 1, 0);
        tick(); #1;
        status("abort.idle", 0, 0, 0, 0);
        check("abort.pe_config", 64'(pe_config), 64'(0));
        check("abort.ifmap_ready", 64'(src_ifmap_ready), 64'(0));
        check("abort.ifmap_en", 64'(pe_ifmap[DS]), 64'(0));
        rst = 1'b0; start = 1'b0;
        tick(); #1;
        status("abort.no_done", 0, 0, 0, 0);
        cfg_word = cfg_b; ifmap_cnt = 16'd1; start = 1'b1;
        tick(); start = 1'b0; #1;
        check("replay.config", 64'(pe_config), 64'({1'b1, cfg_b}));
        tick(); #1;
        status("replay.compute", 1, 0, 1, 0);
        check("replay.ifmap_ready", 64'(src_ifmap_ready), 64'(1));
        tick(); #1;
        status("replay.done", 1, 1, 0, 0);
        tick(); #1;
        status("replay.idle", 0, 0, 0, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
